dcache_port_arb: RTL and testbench
==================================

# dcache_port_arb

Single-port Dcache scheduler between the load/store queue and the Dcache. It holds one load request from the LSQ and drains retired stores through an in-order store buffer. Each cycle it decides which of the two uses the one Dcache port. It sits between the LSQ load issue outputs, the ROB store-retire path and the Dcache request port.

## Interface
Parameters:
- `STB_DEPTH`, default 8: store buffer entries, power of two.
- `STB_BITS`, default 3: log2(`STB_DEPTH`).
- `STARVE_LIMIT`, default 4: number of consecutive load grants allowed while a store waits.

Ports:
- `clock` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `lsq_rd_mem` in 1: load request valid.
- `lsq_addr` in 64: load address.
- `lsq_pr_idx` in 7: load destination physical register.
- `lsq_ar_idx` in 5: load destination architectural register.
- `lsq_dcache_avail` out 1: load holding register empty; the LSQ may send a load.
- `st_push0`, `st_push1` in 1 each: retired store valid; `st_push0` is the older.
- `st_addr0`, `st_addr1` in 64: store addresses.
- `st_value0`, `st_value1` in 64: store data.
- `stb_free` out 2: free entries, saturated at 2.
- `stb_empty` out 1: store buffer empty.
- `dc_ready` in 1: Dcache accepts the presented command this cycle.
- `dc_command` out 2: 0 = NONE, 1 = LOAD, 2 = STORE.
- `dc_addr` out 64: request address.
- `dc_st_data` out 64: store data.
- `dc_pr_idx` out 7, `dc_ar_idx` out 5: load tags.
- `fwd_valid` out 1: load completed by forwarding.
- `fwd_pr_idx` out 7, `fwd_ar_idx` out 5: forwarded load tags.
- `fwd_value` out 64: forwarded data.

## Operation
Load holding register:
- Accept a load when `lsq_rd_mem & lsq_dcache_avail`.
- `lsq_dcache_avail = ~ld_valid`, taken from registered state only.
- Clear `ld_valid` at the clock edge where the load is granted to the Dcache (LOAD and `dc_ready`) or forwarded.

Store buffer:
- Circular FIFO with head, tail and a `STB_BITS+1` count. Pointers wrap modulo `STB_DEPTH`.
- `st_push0` is written at the tail, `st_push1` at tail+1. If only `st_push1` is asserted, it is written at the tail.
- `stb_free` is computed from the registered count. A pop in the same cycle does not raise it.
- Pushes beyond `stb_free` are dropped. The sender guarantees this never happens.
- The head entry pops on a STORE grant with `dc_ready`.

Address hazard:
- Compare the held load address against every valid entry, all 64 bits.

Arbitration, combinational from registered state, highest priority first:
1. Buffer full: STORE.
2. `starve_cnt == STARVE_LIMIT` and buffer non-empty: STORE.
3. Held load eligible: LOAD.
4. Buffer non-empty: STORE.
5. Otherwise: NONE.

Load eligibility and starvation:
- A load is ineligible while any buffer entry matches its address (no-forward build).
- `starve_cnt` increments on each LOAD grant taken while the buffer is non-empty. It saturates at `STARVE_LIMIT`.
- `starve_cnt` clears on each STORE grant.

Outputs and commit:
- `dc_*` outputs show the head entry (STORE) or the held load (LOAD). All of them are zero when NONE.
- When `dc_ready` is low, nothing commits and the same decision is re-evaluated next cycle.

Reset:
- Head, tail, count, `ld_valid` and `starve_cnt` all go to 0.
- Outputs after reset: `lsq_dcache_avail=1`, `stb_free=2`, `stb_empty=1`, `dc_command=0`, all data and tag outputs 0, `fwd_valid=0`.
- A reset asserted mid-operation discards buffered stores and the held load.

## Timing
- A load accepted at edge N can drive `dc_command=LOAD` in cycle N+1.
- A forwarded load (see Configuration) drives `fwd_valid` in cycle N+1 and releases the holding register at edge N+1.
- A store pushed at edge N is visible to arbitration, and can drive STORE, in cycle N+1.
- A push and a pop in the same cycle are both honoured; the count changes by push-pop.
- A load and a push arriving in the same cycle: the hazard check at N+1 includes the new entries.

## Configuration
`STB_FORWARD_EN`
- Defined:
  - A held load whose address matches any buffer entry completes via `fwd_*` with the youngest matching entry's value. It does not use the Dcache port.
  - `fwd_valid` is asserted for exactly one cycle. `dc_command` that cycle is STORE or NONE by the normal rules, with the load excluded.
- Undefined:
  - `fwd_*` outputs are tied to 0.
  - A matching load waits, ineligible, until the matching entries drain.

## Test plan
- Reset, then push stores 0x100/0xA and 0x108/0xB in one cycle with `dc_ready=1` -> STORE 0x100 data 0xA, next cycle STORE 0x108 data 0xB, then `stb_empty=1`.
- Fill 8 entries with `dc_ready=0` -> `stb_free=0`. A load at 0x200 stays held; raising `dc_ready` gives STORE first, because the buffer is full.
- One store at 0x300 held back by 6 back-to-back non-matching loads -> after 4 LOAD grants, STORE 0x300 is issued, then loads resume.
- Store 0x400/0x55 buffered, load at 0x400 with pr 12 -> `STB_FORWARD_EN` build: `fwd_valid` with pr 12 and value 0x55 next cycle. Other build: STORE 0x400 first, then LOAD 0x400.
- Two stores at 0x500 (0x1 older, 0x2 younger), load at 0x500 -> forwarded value 0x2.
- Assert `reset` with 3 buffered stores and a held load -> next cycle `dc_command=0`, `stb_empty=1`, `lsq_dcache_avail=1`, `stb_free=2`.

Source files
------------

// File: rtl/dcache_port_arb.sv
`timescale 1ns/1ps
// Single Dcache port scheduler: one held load from the LSQ versus an in-order retired-store buffer.
// Define STB_FORWARD_EN to complete address-matching loads from the store buffer instead of waiting.
module dcache_port_arb #(
    parameter int STB_DEPTH    = 8,
    parameter int STB_BITS     = 3,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        lsq_rd_mem,
    input  logic [63:0] lsq_addr,
    input  logic [6:0]  lsq_pr_idx,
    input  logic [4:0]  lsq_ar_idx,
    output logic        lsq_dcache_avail,
    input  logic        st_push0,
    input  logic        st_push1,
    input  logic [63:0] st_addr0,
    input  logic [63:0] st_addr1,
    input  logic [63:0] st_value0,
    input  logic [63:0] st_value1,
    output logic [1:0]  stb_free,
    output logic        stb_empty,
    input  logic        dc_ready,
    output logic [1:0]  dc_command,
    output logic [63:0] dc_addr,
    output logic [63:0] dc_st_data,
    output logic [6:0]  dc_pr_idx,
    output logic [4:0]  dc_ar_idx,
    output logic        fwd_valid,
    output logic [6:0]  fwd_pr_idx,
    output logic [4:0]  fwd_ar_idx,
    output logic [63:0] fwd_value
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_LOAD  = 2'd1,
        CMD_STORE = 2'd2
    } cmd_e;

    logic                ld_valid_q, ld_valid_d;
    logic [63:0]         ld_addr_q, ld_addr_d;
    logic [6:0]          ld_pr_q, ld_pr_d;
    logic [4:0]          ld_ar_q, ld_ar_d;
    logic [STB_BITS-1:0] head_q, head_d, tail_q, tail_d;
    logic [STB_BITS:0]   count_q, count_d;
    logic [SC_W-1:0]     starve_q, starve_d;

    logic [63:0] stb_addr_q [STB_DEPTH];
    logic [63:0] stb_data_q [STB_DEPTH];

    logic              full, nonempty, hit, fwd_take, ld_grant, st_grant;
    logic [STB_BITS:0] space;
    logic              wa_en, wb_en;
    logic [63:0]       wa_addr, wa_data;
    logic [1:0]        n_push;
    logic [63:0]       fwd_data;
    cmd_e              cmd;

    assign full     = (count_q == (STB_BITS+1)'(STB_DEPTH));
    assign nonempty = (count_q != '0);
    assign space    = (STB_BITS+1)'(STB_DEPTH) - count_q;

    // Walk oldest to youngest so the last match seen is the youngest store.
    always_comb begin
        logic [STB_BITS-1:0] idx;
        hit      = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < STB_DEPTH; k++) begin
            idx = head_q + STB_BITS'(k);
            if (((STB_BITS+1)'(k) < count_q) && (stb_addr_q[idx] == ld_addr_q)) begin
                hit      = 1'b1;
                fwd_data = stb_data_q[idx];
            end
        end
    end

    always_comb begin
        cmd = CMD_NONE;
        if (full)
            cmd = CMD_STORE;
        else if ((starve_q == SC_W'(STARVE_LIMIT)) && nonempty)
            cmd = CMD_STORE;
        else if (ld_valid_q && !hit)
            cmd = CMD_LOAD;
        else if (nonempty)
            cmd = CMD_STORE;
    end

    assign ld_grant = (cmd == CMD_LOAD) && dc_ready;
    assign st_grant = (cmd == CMD_STORE) && dc_ready;

`ifdef STB_FORWARD_EN
    assign fwd_take   = ld_valid_q && hit;
    assign fwd_valid  = fwd_take;
    assign fwd_pr_idx = fwd_take ? ld_pr_q : '0;
    assign fwd_ar_idx = fwd_take ? ld_ar_q : '0;
    assign fwd_value  = fwd_take ? fwd_data : '0;
`else
    assign fwd_take   = 1'b0;
    assign fwd_valid  = 1'b0;
    assign fwd_pr_idx = '0;
    assign fwd_ar_idx = '0;
    assign fwd_value  = '0;
    logic unused_fwd;
    assign unused_fwd = ^fwd_data;
`endif

    assign lsq_dcache_avail = ~ld_valid_q;
    assign stb_free         = (space >= (STB_BITS+1)'(2)) ? 2'd2 : space[1:0];
    assign stb_empty        = ~nonempty;
    assign dc_command       = cmd;
    assign dc_addr          = (cmd == CMD_STORE) ? stb_addr_q[head_q] :
                              (cmd == CMD_LOAD)  ? ld_addr_q : '0;
    assign dc_st_data       = (cmd == CMD_STORE) ? stb_data_q[head_q] : '0;
    assign dc_pr_idx        = (cmd == CMD_LOAD) ? ld_pr_q : '0;
    assign dc_ar_idx        = (cmd == CMD_LOAD) ? ld_ar_q : '0;

    // A lone push1 lands at the tail so entries always stay contiguous.
    always_comb begin
        wa_en   = 1'b0;
        wb_en   = 1'b0;
        wa_addr = st_addr0;
        wa_data = st_value0;
        if (st_push0 || st_push1) begin
            wa_en = (stb_free != 2'd0);
            if (!st_push0) begin
                wa_addr = st_addr1;
                wa_data = st_value1;
            end
            wb_en = st_push0 && st_push1 && (stb_free == 2'd2);
        end
        n_push = {1'b0, wa_en} + {1'b0, wb_en};
    end

    always_comb begin
        ld_valid_d = ld_valid_q;
        ld_addr_d  = ld_addr_q;
        ld_pr_d    = ld_pr_q;
        ld_ar_d    = ld_ar_q;
        if (ld_grant || fwd_take)
            ld_valid_d = 1'b0;
        if (lsq_rd_mem && lsq_dcache_avail) begin
            ld_valid_d = 1'b1;
            ld_addr_d  = lsq_addr;
            ld_pr_d    = lsq_pr_idx;
            ld_ar_d    = lsq_ar_idx;
        end

        starve_d = starve_q;
        if (st_grant)
            starve_d = '0;
        else if (ld_grant && nonempty && (starve_q != SC_W'(STARVE_LIMIT)))
            starve_d = starve_q + SC_W'(1);

        head_d  = head_q + STB_BITS'(st_grant);
        tail_d  = tail_q + STB_BITS'(n_push);
        count_d = count_q + (STB_BITS+1)'(n_push) - (STB_BITS+1)'(st_grant);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            ld_valid_q <= 1'b0;
            ld_addr_q  <= '0;
            ld_pr_q    <= '0;
            ld_ar_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            starve_q   <= '0;
        end else begin
            ld_valid_q <= ld_valid_d;
            ld_addr_q  <= ld_addr_d;
            ld_pr_q    <= ld_pr_d;
            ld_ar_q    <= ld_ar_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
        end
    end

    // NOTE: buffer storage has no reset; count_q alone decides which entries are live.
    always_ff @(posedge clock) begin
        if (wa_en) begin
            stb_addr_q[tail_q] <= wa_addr;
            stb_data_q[tail_q] <= wa_data;
        end
        if (wb_en) begin
            stb_addr_q[tail_q + STB_BITS'(1)] <= st_addr1;
            stb_data_q[tail_q + STB_BITS'(1)] <= st_value1;
        end
    end

endmodule

// File: tb/tb_dcache_port_arb.sv
`timescale 1ns/1ps
// Scoreboard bench for dcache_port_arb: directed stimulus queues expected port events,
// a negedge monitor pops and compares every granted command or forward.
module tb_dcache_port_arb;

    localparam logic [1:0] K_LOAD = 2'd1, K_STORE = 2'd2, K_FWD = 2'd3;

    logic        clock = 1'b0;
    logic        reset;
    logic        lsq_rd_mem;
    logic [63:0] lsq_addr;
    logic [6:0]  lsq_pr_idx;
    logic [4:0]  lsq_ar_idx;
    logic        lsq_dcache_avail;
    logic        st_push0, st_push1;
    logic [63:0] st_addr0, st_addr1, st_value0, st_value1;
    logic [1:0]  stb_free;
    logic        stb_empty;
    logic        dc_ready;
    logic [1:0]  dc_command;
    logic [63:0] dc_addr, dc_st_data;
    logic [6:0]  dc_pr_idx;
    logic [4:0]  dc_ar_idx;
    logic        fwd_valid;
    logic [6:0]  fwd_pr_idx;
    logic [4:0]  fwd_ar_idx;
    logic [63:0] fwd_value;

    always #5 clock = ~clock;

    dcache_port_arb dut (
        .clock(clock), .reset(reset),
        .lsq_rd_mem(lsq_rd_mem), .lsq_addr(lsq_addr), .lsq_pr_idx(lsq_pr_idx),
        .lsq_ar_idx(lsq_ar_idx), .lsq_dcache_avail(lsq_dcache_avail),
        .st_push0(st_push0), .st_push1(st_push1), .st_addr0(st_addr0), .st_addr1(st_addr1),
        .st_value0(st_value0), .st_value1(st_value1), .stb_free(stb_free), .stb_empty(stb_empty),
        .dc_ready(dc_ready), .dc_command(dc_command), .dc_addr(dc_addr), .dc_st_data(dc_st_data),
        .dc_pr_idx(dc_pr_idx), .dc_ar_idx(dc_ar_idx),
        .fwd_valid(fwd_valid), .fwd_pr_idx(fwd_pr_idx), .fwd_ar_idx(fwd_ar_idx), .fwd_value(fwd_value)
    );

    typedef struct {
        logic [1:0]  kind;
        logic [63:0] addr;
        logic [63:0] data;
        logic [6:0]  pr;
        logic [4:0]  ar;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input logic [1:0] kind, input logic [63:0] addr, input logic [63:0] data,
                             input logic [6:0] pr, input logic [4:0] ar);
        exp_t e;
        e.kind = kind; e.addr = addr; e.data = data; e.pr = pr; e.ar = ar;
        exp_q.push_back(e);
    endtask

    task automatic observe(input logic [1:0] kind, input logic [63:0] addr, input logic [63:0] data,
                           input logic [6:0] pr, input logic [4:0] ar);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d addr 0x%0h data 0x%0h expected no event",
                     kind, addr, data);
        end else begin
            e = exp_q.pop_front();
            check("ev_kind", 64'(kind), 64'(e.kind));
            if (e.kind == K_LOAD) begin
                check("load_addr", addr, e.addr);
                check("load_pr", 64'(pr), 64'(e.pr));
                check("load_ar", 64'(ar), 64'(e.ar));
            end else if (e.kind == K_STORE) begin
                check("store_addr", addr, e.addr);
                check("store_data", data, e.data);
            end else begin
                check("fwd_value", data, e.data);
                check("fwd_pr", 64'(pr), 64'(e.pr));
                check("fwd_ar", 64'(ar), 64'(e.ar));
            end
        end
    endtask

    always @(negedge clock) begin
        if (reset === 1'b0) begin
            if (fwd_valid === 1'b1)
                observe(K_FWD, 64'h0, fwd_value, fwd_pr_idx, fwd_ar_idx);
            if (dc_ready === 1'b1 && dc_command !== 2'd0)
                observe(dc_command, dc_addr, dc_st_data, dc_pr_idx, dc_ar_idx);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_pulses();
        lsq_rd_mem = 1'b0;
        st_push0   = 1'b0;
        st_push1   = 1'b0;
    endtask

    task automatic set_load(input logic [63:0] a, input logic [6:0] pr, input logic [4:0] ar);
        lsq_rd_mem = 1'b1; lsq_addr = a; lsq_pr_idx = pr; lsq_ar_idx = ar;
    endtask

    task automatic set_push0(input logic [63:0] a, input logic [63:0] d);
        st_push0 = 1'b1; st_addr0 = a; st_value0 = d;
    endtask

    task automatic set_push1(input logic [63:0] a, input logic [63:0] d);
        st_push1 = 1'b1; st_addr1 = a; st_value1 = d;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; dc_ready = 1'b0;
        lsq_addr = '0; lsq_pr_idx = '0; lsq_ar_idx = '0;
        st_addr0 = '0; st_addr1 = '0; st_value0 = '0; st_value1 = '0;
        clear_pulses();
        repeat (2) step();
        check("rst_avail", 64'(lsq_dcache_avail), 64'd1);
        check("rst_free", 64'(stb_free), 64'd2);
        check("rst_empty", 64'(stb_empty), 64'd1);
        check("rst_cmd", 64'(dc_command), 64'd0);
        check("rst_dc_addr", dc_addr, 64'd0);
        check("rst_dc_data", dc_st_data, 64'd0);
        check("rst_fwd_valid", 64'(fwd_valid), 64'd0);
        reset = 1'b0;
        step();

        // Two stores in one cycle drain in order.
        dc_ready = 1'b1;
        expect_ev(K_STORE, 64'h100, 64'hA, 0, 0);
        expect_ev(K_STORE, 64'h108, 64'hB, 0, 0);
        set_push0(64'h100, 64'hA);
        set_push1(64'h108, 64'hB);
        step();
        clear_pulses();
        wait_drain("s1", 10);
        check("s1_empty", 64'(stb_empty), 64'd1);
        check("s1_free", 64'(stb_free), 64'd2);

        // Fill the buffer while the cache stalls; full buffer outranks a held load.
        dc_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_push0(64'h1000 + 64'(16 * i), 64'h10 + 64'(2 * i));
            set_push1(64'h1008 + 64'(16 * i), 64'h11 + 64'(2 * i));
            step();
        end
        clear_pulses();
        check("s2_free_full", 64'(stb_free), 64'd0);
        check("s2_not_empty", 64'(stb_empty), 64'd0);
        set_load(64'h200, 7'd5, 5'd3);
        step();
        clear_pulses();
        check("s2_avail_held", 64'(lsq_dcache_avail), 64'd0);
        check("s2_cmd_full_store", 64'(dc_command), 64'(K_STORE));
        expect_ev(K_STORE, 64'h1000, 64'h10, 0, 0);
        expect_ev(K_LOAD, 64'h200, 64'h0, 7'd5, 5'd3);
        for (int i = 1; i < 8; i++)
            expect_ev(K_STORE, 64'h1000 + 64'(8 * i), 64'h10 + 64'(i), 0, 0);
        dc_ready = 1'b1;
        wait_drain("s2", 30);
        check("s2_empty", 64'(stb_empty), 64'd1);

        // Starvation: 4 load grants, then the waiting store, then loads resume.
        dc_ready = 1'b0;
        set_push0(64'h300, 64'h33);
        step();
        clear_pulses();
        for (int i = 0; i < 4; i++)
            expect_ev(K_LOAD, 64'h2000 + 64'(16 * i), 64'h0, 7'(i + 1), 5'(i + 1));
        expect_ev(K_STORE, 64'h300, 64'h33, 0, 0);
        for (int i = 4; i < 6; i++)
            expect_ev(K_LOAD, 64'h2000 + 64'(16 * i), 64'h0, 7'(i + 1), 5'(i + 1));
        for (int i = 0; i < 6; i++) begin
            dc_ready = 1'b0;
            set_load(64'h2000 + 64'(16 * i), 7'(i + 1), 5'(i + 1));
            step();
            clear_pulses();
            dc_ready = 1'b1;
            n = 0;
            do begin
                step();
                n++;
            end while (lsq_dcache_avail !== 1'b1 && n < 8);
            check("s3_load_released", 64'(lsq_dcache_avail), 64'd1);
        end
        dc_ready = 1'b0;
        wait_drain("s3", 5);

        // Load matching a buffered store, pushed in the same cycle.
        set_push0(64'h400, 64'h55);
        set_load(64'h400, 7'd12, 5'd7);
`ifdef STB_FORWARD_EN
        expect_ev(K_FWD, 64'h0, 64'h55, 7'd12, 5'd7);
        expect_ev(K_STORE, 64'h400, 64'h55, 0, 0);
`else
        expect_ev(K_STORE, 64'h400, 64'h55, 0, 0);
        expect_ev(K_LOAD, 64'h400, 64'h0, 7'd12, 5'd7);
`endif
        step();
        clear_pulses();
        check("s4_cmd_store", 64'(dc_command), 64'(K_STORE));
        step();
`ifdef STB_FORWARD_EN
        check("s4_avail_after_fwd", 64'(lsq_dcache_avail), 64'd1);
`else
        check("s4_avail_waiting", 64'(lsq_dcache_avail), 64'd0);
`endif
        dc_ready = 1'b1;
        wait_drain("s4", 10);
        dc_ready = 1'b0;

        // Two matching stores: the younger value is the one forwarded.
        set_push0(64'h500, 64'h1);
        set_push1(64'h500, 64'h2);
        set_load(64'h500, 7'd20, 5'd9);
`ifdef STB_FORWARD_EN
        expect_ev(K_FWD, 64'h0, 64'h2, 7'd20, 5'd9);
        expect_ev(K_STORE, 64'h500, 64'h1, 0, 0);
        expect_ev(K_STORE, 64'h500, 64'h2, 0, 0);
`else
        expect_ev(K_STORE, 64'h500, 64'h1, 0, 0);
        expect_ev(K_STORE, 64'h500, 64'h2, 0, 0);
        expect_ev(K_LOAD, 64'h500, 64'h0, 7'd20, 5'd9);
`endif
        step();
        clear_pulses();
        dc_ready = 1'b1;
        wait_drain("s5", 10);
        dc_ready = 1'b0;

        // Mid-operation reset discards buffered stores and the held load.
        set_push0(64'h800, 64'h81);
        set_push1(64'h808, 64'h82);
        step();
        clear_pulses();
        set_push0(64'h810, 64'h83);
        set_load(64'h700, 7'd3, 5'd2);
        step();
        clear_pulses();
        check("s6_avail_held", 64'(lsq_dcache_avail), 64'd0);
        check("s6_not_empty", 64'(stb_empty), 64'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("s6_cmd", 64'(dc_command), 64'd0);
        check("s6_empty", 64'(stb_empty), 64'd1);
        check("s6_avail", 64'(lsq_dcache_avail), 64'd1);
        check("s6_free", 64'(stb_free), 64'd2);
        check("s6_fwd_valid", 64'(fwd_valid), 64'd0);
        dc_ready = 1'b1;
        repeat (4) step();
        check("s6_still_empty", 64'(stb_empty), 64'd1);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
